// File: rtl/fp_pkg.sv
// Shared FP32 constants, field widths and the power-unit state type.
// Imported by the multiplier core and the sequential power unit.
package fp_pkg;

    localparam int unsigned FP_SIGN_W = 1;
    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned FP_FRAC_W = 23;
    localparam int unsigned FP_W      = FP_SIGN_W + FP_EXP_W + FP_FRAC_W;
    localparam int unsigned FP_BIAS   = 127;

    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F800000;
    localparam logic [FP_W-1:0] FP_PINF = 32'h7F800000;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h00000000;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } pow_state_t;

endpackage

// File: rtl/fp32_mul_core.sv
// Pipelined FP32 multiplier: flush-to-zero, round-to-nearest-even, saturating,
// with overflow/underflow flags travelling alongside the product.
module fp32_mul_core
    import fp_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        ovf,
    output logic        unf
);

    logic                sa, sb, sy;
    logic [7:0]          ea, eb;
    logic [22:0]         fa, fb;
    logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0]         prod;
    logic signed [9:0]   exp_c;
    logic [22:0]         mant;
    logic                guard, sticky, round_up;
    logic [23:0]         rnd;
    logic [31:0]         y_c;
    logic                ovf_c, unf_c;
    logic [33:0]         pipe_q [MUL_LAT];

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    assign sy     = sa ^ sb;
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

    always_comb begin
        y_c    = FP_ZERO;
        ovf_c  = 1'b0;
        unf_c  = 1'b0;
        prod   = {1'b1, fa} * {1'b1, fb};
        exp_c  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        // Normalise the 48-bit product to 1.xxx with guard and sticky bits
        if (prod[47]) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_c  = exp_c + 10'sd1;
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        round_up = guard && (sticky || mant[0]);
        rnd      = {1'b0, mant} + {23'd0, round_up};
        if (rnd[23]) begin
            exp_c = exp_c + 10'sd1;
        end

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            y_c = FP_QNAN;
        end else if (a_inf || b_inf) begin
            y_c = {sy, FP_PINF[30:0]};
        end else if (a_zero || b_zero) begin
            y_c = {sy, FP_ZERO[30:0]};
        end else if (exp_c >= 10'sd255) begin
            y_c   = {sy, FP_PINF[30:0]};
            ovf_c = 1'b1;
        end else if (exp_c <= 10'sd0) begin
            y_c   = {sy, FP_ZERO[30:0]};
            unf_c = 1'b1;
        end else begin
            y_c = {sy, exp_c[7:0], rnd[22:0]};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= {ovf_c, unf_c, y_c};
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign {ovf, unf, y} = pipe_q[MUL_LAT-1];

endmodule

// File: rtl/fp32_pow_seq.sv
// Sequential FP32 integer power A^B by right-to-left square-and-multiply,
// with start/busy/done handshake and sticky overflow/underflow flags.
module fp32_pow_seq
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W   = 24,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [31:0]      A,
    input  logic [EXP_W-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    pow_state_t       state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      result_q, result_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic [EXP_W-1:0] e_shr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [31:0]      sq_y, pr_y;
    logic             sq_ovf, sq_unf, pr_ovf, pr_unf;

    assign e_shr = e_q >> 1;

    fp32_mul_core #(
        .MUL_LAT(MUL_LAT)
    ) u_sq (
        .CLK(CLK),
        .RST(RST),
        .a  (base_q),
        .b  (base_q),
        .y  (sq_y),
        .ovf(sq_ovf),
        .unf(sq_unf)
    );

    fp32_mul_core #(
        .MUL_LAT(MUL_LAT)
    ) u_pr (
        .CLK(CLK),
        .RST(RST),
        .a  (acc_q),
        .b  (base_q),
        .y  (pr_y),
        .ovf(pr_ovf),
        .unf(pr_unf)
    );

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        acc_d    = acc_q;
        result_d = result_q;
        e_d      = e_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = A;
                    e_d     = B;
                    acc_d   = FP_ONE;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // Result and done are registered together so they appear in the DONE cycle
                if (e_q == '0) begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end else begin
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    if (e_q[0]) begin
                        acc_d = pr_y;
                        ovf_d = ovf_d | pr_ovf;
                        unf_d = unf_d | pr_unf;
                    end
                    // A square that will never be consumed must not raise flags
                    if (e_shr != '0) begin
                        ovf_d = ovf_d | sq_ovf;
                        unf_d = unf_d | sq_unf;
                    end
                    base_d  = sq_y;
                    e_d     = e_shr;
                    state_d = StIssue;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= StIdle;
            base_q   <= '0;
            acc_q    <= '0;
            result_q <= FP_ONE;
            e_q      <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            e_q      <= e_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign busy      = (state_q == StIssue) || (state_q == StWait);
    assign done      = done_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
